// File: rtl/pipeline_if_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pipeline_defs (package)                                |
// | Brief   : Shared PCSrc encodings, vector addresses and NOP word  |
// |           for the fetch stage and ID control.                    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package pipeline_defs;

    typedef enum logic [2:0] {
        PCSRC_SEQ    = 3'd0,
        PCSRC_BRANCH = 3'd1,
        PCSRC_JUMP   = 3'd2,
        PCSRC_JREG   = 3'd3,
        PCSRC_ILLOP  = 3'd4,
        PCSRC_XADR   = 3'd5
    } pcsrc_e;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] XADR_PC  = 32'h8000_0008;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Bit 31 is the kernel/supervisor flag and must survive sequential fetch.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_pc_sel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pipeline_pc_sel                                        |
// | Brief   : Combinational next-PC mux, redirect and flush decode.  |
// |           IF_DELAY_SLOT_EN: branch/jump redirects keep the slot. |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module pipeline_pc_sel
    import pipeline_defs::*;
(
    input  logic [2:0]  i_pcsrc,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic [31:0] i_conba,
    input  logic [25:0] i_jt,
    input  logic [31:0] i_pcout,
    input  logic [3:0]  i_id_pc_hi,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_next_pc,
    output logic        o_redirect,
    output logic        o_flush
);

    logic w_exc;

    always_comb begin
        o_next_pc = i_pc4;
        case (pcsrc_e'(i_pcsrc))
            PCSRC_BRANCH: o_next_pc = i_branch ? i_conba : i_pc4;
            PCSRC_JUMP:   o_next_pc = {i_id_pc_hi, i_jt, 2'b00};
            PCSRC_JREG:   o_next_pc = i_pcout;
            PCSRC_ILLOP:  o_next_pc = ILLOP_PC;
            PCSRC_XADR:   o_next_pc = XADR_PC;
            default:      o_next_pc = i_pc4;
        endcase
    end

    assign w_exc      = (i_pcsrc == PCSRC_ILLOP) || (i_pcsrc == PCSRC_XADR);
    assign o_redirect = ((i_pcsrc == PCSRC_BRANCH) && i_branch) || i_jump || w_exc;

`ifdef IF_DELAY_SLOT_EN
    // Exceptions still squash the slot; control transfers execute it.
    assign o_flush = w_exc;
`else
    assign o_flush = o_redirect;
`endif

endmodule
`default_nettype wire

// File: rtl/pipeline_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pipeline_if                                            |
// | Brief   : Fetch stage: PC register and IF/ID pipeline register.  |
// |           Honours IF_DELAY_SLOT_EN via pipeline_pc_sel.          |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module pipeline_if
    import pipeline_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic        IDcontrol_Branch,
    input  logic        IDcontrol_Jump,
    input  logic [31:0] ConBA,
    input  logic [25:0] JT,
    input  logic [31:0] PCout,
    input  logic        Stall,
    input  logic [31:0] IF_instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instruction
);

    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_flush;

    assign w_pc4 = pc_plus4(r_pc);

    pipeline_pc_sel u_pc_sel (
        .i_pcsrc    (PCSrc),
        .i_branch   (IDcontrol_Branch),
        .i_jump     (IDcontrol_Jump),
        .i_conba    (ConBA),
        .i_jt       (JT),
        .i_pcout    (PCout),
        .i_id_pc_hi (r_id_pc[31:28]),
        .i_pc4      (w_pc4),
        .o_next_pc  (w_next_pc),
        .o_redirect (w_redirect),
        .o_flush    (w_flush)
    );

    // The flushed slot still records its PC+4 so an IRQ on a bubble returns correctly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_id_pc    <= RESET_PC;
            r_id_instr <= NOP;
        end else if (!Stall) begin
            r_pc       <= w_next_pc;
            r_id_pc    <= w_pc4;
            r_id_instr <= w_flush ? NOP : IF_instruction;
        end
    end

    assign IF_PC          = r_pc;
    assign ID_PC          = r_id_pc;
    assign ID_instruction = r_id_instr;

    logic w_unused;
    assign w_unused = w_redirect;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_pipeline_if                                         |
// | Brief   : Directed + random check of pipeline_if against a model.|
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_pipeline_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PCSrc;
    logic        IDcontrol_Branch;
    logic        IDcontrol_Jump;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic [31:0] PCout;
    logic        Stall;
    logic [31:0] IF_instruction;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic [31:0] ID_instruction;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] e_pc, e_idpc, e_idinstr;

    pipeline_if dut (
        .clk              (clk),
        .reset            (reset),
        .PCSrc            (PCSrc),
        .IDcontrol_Branch (IDcontrol_Branch),
        .IDcontrol_Jump   (IDcontrol_Jump),
        .ConBA            (ConBA),
        .JT               (JT),
        .PCout            (PCout),
        .Stall            (Stall),
        .IF_instruction   (IF_instruction),
        .IF_PC            (IF_PC),
        .ID_PC            (ID_PC),
        .ID_instruction   (ID_instruction)
    );

    always #5 clk = ~clk;

    // Instruction memory: never returns zero, so a bubble is distinguishable.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always_comb IF_instruction = imem(IF_PC);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".IF_PC"}, IF_PC, e_pc);
        chk({tag, ".ID_PC"}, ID_PC, e_idpc);
        chk({tag, ".ID_instr"}, ID_instruction, e_idinstr);
    endtask

    task automatic model_reset();
        e_pc      = 32'h8000_0000;
        e_idpc    = 32'h8000_0000;
        e_idinstr = 32'h0;
    endtask

    // Apply one cycle of ID-side inputs, advance the reference model, check after the edge.
    task automatic cycle(input string tag, input logic [2:0] src, input logic br,
                         input logic jmp, input logic [31:0] cba, input logic [25:0] jt,
                         input logic [31:0] pco, input logic stl);
        logic [31:0] seq, tgt;
        logic        taken, kill;
        PCSrc = src; IDcontrol_Branch = br; IDcontrol_Jump = jmp;
        ConBA = cba; JT = jt; PCout = pco; Stall = stl;
        seq = {e_pc[31], e_pc[30:0] + 31'd4};
        if (!stl) begin
            if (src == 3'd1 && br)  tgt = cba;
            else if (src == 3'd2)   tgt = {e_idpc[31:28], jt, 2'b00};
            else if (src == 3'd3)   tgt = pco;
            else if (src == 3'd4)   tgt = 32'h8000_0004;
            else if (src == 3'd5)   tgt = 32'h8000_0008;
            else                    tgt = seq;
            taken = (src == 3'd1 && br) || jmp || src == 3'd4 || src == 3'd5;
`ifdef IF_DELAY_SLOT_EN
            kill = (src == 3'd4 || src == 3'd5);
`else
            kill = taken;
`endif
            e_idinstr = kill ? 32'h0 : imem(e_pc);
            e_idpc    = seq;
            e_pc      = tgt;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic seq_step(input string tag);
        cycle(tag, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; PCSrc = 3'd0; IDcontrol_Branch = 1'b0; IDcontrol_Jump = 1'b0;
        ConBA = 32'h0; JT = 26'h0; PCout = 32'h0; Stall = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk_all("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("release");

        // Sequential fetch from reset vector.
        seq_step("seq0");
        seq_step("seq1");
        seq_step("seq2");

        // Taken branch then not-taken branch.
        cycle("br_taken", 3'd1, 1'b1, 1'b0, 32'h8000_0040, 26'h0, 32'h0, 1'b0);
        seq_step("after_br");
        cycle("br_not", 3'd1, 1'b0, 1'b0, 32'h8000_0100, 26'h0, 32'h0, 1'b0);

        // Stall two cycles with a pending JR; redirect only when released.
        cycle("stall0", 3'd3, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0000_0100, 1'b1);
        cycle("stall1", 3'd3, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0000_0100, 1'b1);
        cycle("jr", 3'd3, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0000_0100, 1'b0);

        // Steer PC to 0x10, then take ILLOP; then a J redirect.
        cycle("jr10", 3'd3, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0000_0010, 1'b0);
        cycle("illop", 3'd4, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        cycle("xadr", 3'd5, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        cycle("jump", 3'd2, 1'b0, 1'b1, 32'h0, 26'h123_4567, 32'h0, 1'b0);
        seq_step("after_j");

        // Bit-31 preserving increment at the top of the low half.
        cycle("jr_top", 3'd3, 1'b0, 1'b1, 32'h0, 26'h0, 32'h7FFF_FFFC, 1'b0);
        seq_step("wrap");

        // Asynchronous reset mid-cycle with a redirect pending.
        PCSrc = 3'd1; IDcontrol_Branch = 1'b1; ConBA = 32'h0000_4000;
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        #3;
        reset = 1'b1;
        seq_step("rst_seq0");
        seq_step("rst_seq1");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            cycle("rand", s, 1'($urandom), (s == 3'd2 || s == 3'd3) ? 1'b1 : 1'($urandom_range(0, 9) == 0),
                  $urandom, 26'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
